// File: rtl/thread_scheduler_if.sv
// Handshake bundle between the miss/refill reporters, the thread scheduler and IF.
// The slave modport is the scheduler's view; the master modport is the surrounding pipeline's view.
interface thread_scheduler_if #(
  parameter int unsigned NTHREADS = 4,
  parameter int unsigned TID_W    = 2
);
  logic [NTHREADS-1:0] ThreadEnable;
  logic                MissValid;
  logic [TID_W-1:0]    MissTID;
  logic                DoneValid;
  logic [TID_W-1:0]    DoneTID;
  logic                Hold;
  logic [TID_W-1:0]    nextthread;
  logic                ThreadValid;
  logic                SwitchAction;
  logic [NTHREADS-1:0] PendingMask;
  logic                AllStalled;

  modport master (
    output ThreadEnable, MissValid, MissTID, DoneValid, DoneTID, Hold,
    input  nextthread, ThreadValid, SwitchAction, PendingMask, AllStalled
  );

  modport slave (
    input  ThreadEnable, MissValid, MissTID, DoneValid, DoneTID, Hold,
    output nextthread, ThreadValid, SwitchAction, PendingMask, AllStalled
  );
endinterface

// File: rtl/thread_scheduler.sv
// Switch-on-event fetch-thread selector with per-thread miss-pending tracking.
// Optional forced time-slice switching is built when QUANTUM_SWITCH_EN is defined.
module thread_scheduler #(
  parameter int unsigned NTHREADS = 4,
  parameter int unsigned TID_W    = 2,
  parameter int unsigned QUANTUM  = 16
) (
  input logic               clk,
  input logic               Reset,
  thread_scheduler_if.slave sif
);

  if (NTHREADS != (1 << TID_W) || QUANTUM == 0) begin : g_bad_cfg
    $error("thread_scheduler: NTHREADS must equal 2**TID_W and QUANTUM must be nonzero");
  end

  logic [NTHREADS-1:0] pend_q, pend_d;
  logic [NTHREADS-1:0] ready_n;
  logic [TID_W-1:0]    next_q, next_d;
  logic                valid_q, valid_d;
  logic                switch_q, switch_d;
  logic                stall_q, stall_d;
  logic                force_sw;
  logic                found;
  logic [TID_W-1:0]    cand;
  logic [TID_W-1:0]    idx;

  // Miss applied after done so a same-cycle miss wins over the completion.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NTHREADS; i++) begin
      if (sif.DoneValid && (sif.DoneTID == TID_W'(i))) pend_d[i] = 1'b0;
      if (sif.MissValid && (sif.MissTID == TID_W'(i))) pend_d[i] = 1'b1;
    end
    ready_n = sif.ThreadEnable & ~pend_d;
  end

  // Round-robin search over the other threads, starting at cur+1 and wrapping.
  always_comb begin
    found = 1'b0;
    cand  = next_q;
    idx   = next_q;
    for (int k = 1; k < NTHREADS; k++) begin
      idx = next_q + TID_W'(k);
      if (!found && ready_n[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
    end
  end

`ifdef QUANTUM_SWITCH_EN
  localparam int unsigned QW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

  logic [QW-1:0] qcnt_q, qcnt_d;

  assign force_sw = valid_q && !sif.Hold && (qcnt_q == QW'(QUANTUM - 1));

  always_comb begin
    qcnt_d = qcnt_q;
    if ((next_d != next_q) || force_sw) begin
      qcnt_d = '0;
    end else if (valid_q && !sif.Hold) begin
      qcnt_d = qcnt_q + QW'(1);
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      qcnt_q <= '0;
    end else begin
      qcnt_q <= qcnt_d;
    end
  end
`else
  assign force_sw = 1'b0;
`endif

  // With no other ready thread the current one is kept, even on a forced switch.
  always_comb begin
    next_d = next_q;
    if (!sif.Hold && (!ready_n[next_q] || force_sw) && found) begin
      next_d = cand;
    end
    valid_d  = ready_n[next_d];
    stall_d  = ~|ready_n;
    switch_d = (next_d != next_q);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pend_q   <= '0;
      next_q   <= '0;
      valid_q  <= 1'b0;
      switch_q <= 1'b0;
      stall_q  <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      next_q   <= next_d;
      valid_q  <= valid_d;
      switch_q <= switch_d;
      stall_q  <= stall_d;
    end
  end

  assign sif.nextthread   = next_q;
  assign sif.ThreadValid  = valid_q;
  assign sif.SwitchAction = switch_q;
  assign sif.PendingMask  = pend_q;
  assign sif.AllStalled   = stall_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler; the default build checks event-driven switching,
// a QUANTUM_SWITCH_EN build checks the forced time-slice rotation instead.
module tb_thread_scheduler;

  logic clk;
  logic Reset;
  int   tests;
  int   fails;

  thread_scheduler_if #(.NTHREADS(4), .TID_W(2)) sif ();

  thread_scheduler #(
    .NTHREADS(4),
    .TID_W   (2),
    .QUANTUM (4)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .sif  (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [1:0] n, input logic tv, input logic sa,
                    input logic [3:0] pm, input logic as);
    chk({tag, ".next"}, {30'd0, sif.nextthread}, {30'd0, n});
    chk({tag, ".valid"}, {31'd0, sif.ThreadValid}, {31'd0, tv});
    chk({tag, ".switch"}, {31'd0, sif.SwitchAction}, {31'd0, sa});
    chk({tag, ".pend"}, {28'd0, sif.PendingMask}, {28'd0, pm});
    chk({tag, ".stall"}, {31'd0, sif.AllStalled}, {31'd0, as});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic mv, input logic [1:0] mt, input logic dv, input logic [1:0] dt);
    sif.MissValid = mv;
    sif.MissTID   = mt;
    sif.DoneValid = dv;
    sif.DoneTID   = dt;
  endtask

  // One cycle with the given events, then events cleared.
  task automatic step(input logic mv, input logic [1:0] mt, input logic dv, input logic [1:0] dt);
    ev(mv, mt, dv, dt);
    tick();
    ev(1'b0, 2'd0, 1'b0, 2'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Reset = 1'b1;
    sif.ThreadEnable = 4'b1111;
    sif.Hold = 1'b0;
    ev(1'b0, 2'd0, 1'b0, 2'd0);
    tick();
    tick();
    st("reset", 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
    Reset = 1'b0;
    tick();
    st("cycle1", 2'd0, 1'b1, 1'b0, 4'h0, 1'b0);

`ifndef QUANTUM_SWITCH_EN
    step(1'b1, 2'd0, 1'b0, 2'd0);
    st("miss0", 2'd1, 1'b1, 1'b1, 4'h1, 1'b0);
    step(1'b1, 2'd1, 1'b0, 2'd0);
    st("miss1", 2'd2, 1'b1, 1'b1, 4'h3, 1'b0);
    step(1'b1, 2'd2, 1'b0, 2'd0);
    st("miss2", 2'd3, 1'b1, 1'b1, 4'h7, 1'b0);
    step(1'b1, 2'd3, 1'b0, 2'd0);
    st("allstall", 2'd3, 1'b0, 1'b0, 4'hF, 1'b1);
    step(1'b0, 2'd0, 1'b1, 2'd2);
    st("wake2", 2'd2, 1'b1, 1'b1, 4'hB, 1'b0);

    // Asynchronous reset mid-operation, observed before the next clock edge.
    Reset = 1'b1;
    #2;
    st("arst", 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    Reset = 1'b0;
    tick();
    st("arst_exit", 2'd0, 1'b1, 1'b0, 4'h0, 1'b0);

    step(1'b1, 2'd2, 1'b0, 2'd0);
    st("miss2_other", 2'd0, 1'b1, 1'b0, 4'h4, 1'b0);
    step(1'b1, 2'd0, 1'b0, 2'd0);
    st("miss0_b", 2'd1, 1'b1, 1'b1, 4'h5, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd0);
    st("done0", 2'd1, 1'b1, 1'b0, 4'h4, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd3);
    st("done_nonpend", 2'd1, 1'b1, 1'b0, 4'h4, 1'b0);
    step(1'b1, 2'd1, 1'b1, 2'd2);
    st("miss1_done2", 2'd2, 1'b1, 1'b1, 4'h2, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd1);
    st("done1", 2'd2, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 2'd3, 1'b0, 2'd0);
    st("miss3", 2'd2, 1'b1, 1'b0, 4'h8, 1'b0);
    step(1'b1, 2'd3, 1'b1, 2'd3);
    st("set_wins", 2'd2, 1'b1, 1'b0, 4'h8, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd3);
    st("done3", 2'd2, 1'b1, 1'b0, 4'h0, 1'b0);

    sif.Hold = 1'b1;
    step(1'b1, 2'd2, 1'b0, 2'd0);
    st("hold_miss", 2'd2, 1'b0, 1'b0, 4'h4, 1'b0);
    tick();
    st("hold_keep", 2'd2, 1'b0, 1'b0, 4'h4, 1'b0);
    sif.Hold = 1'b0;
    tick();
    st("hold_drop", 2'd3, 1'b1, 1'b1, 4'h4, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd2);
    st("done2", 2'd3, 1'b1, 1'b0, 4'h0, 1'b0);

    sif.ThreadEnable = 4'b0111;
    tick();
    st("disable3", 2'd0, 1'b1, 1'b1, 4'h0, 1'b0);
    step(1'b1, 2'd3, 1'b0, 2'd0);
    st("miss_disabled", 2'd0, 1'b1, 1'b0, 4'h8, 1'b0);
    sif.ThreadEnable = 4'b0000;
    tick();
    st("none_enabled", 2'd0, 1'b0, 1'b0, 4'h8, 1'b1);
    sif.ThreadEnable = 4'b1111;
    tick();
    st("reenable", 2'd0, 1'b1, 1'b0, 4'h8, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd3);
    st("done3_b", 2'd0, 1'b1, 1'b0, 4'h0, 1'b0);
`else
    // QUANTUM=4: cycle1 showed thread 0, so ticks 0..2 stay on 0, then switch every 4.
    for (int i = 1; i <= 16; i++) begin
      tick();
      st($sformatf("quantum%0d", i), 2'((i / 4) % 4), 1'b1, (i % 4) == 0, 4'h0, 1'b0);
    end
    tick();
    Reset = 1'b1;
    #2;
    st("q_arst", 2'd0, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    Reset = 1'b0;
    sif.ThreadEnable = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      st($sformatf("q_alone%0d", i), 2'd0, 1'b1, 1'b0, 4'h0, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
